// File: rtl/pose_defs.sv
// Pose keyboard definitions: scan codes, key indices and the per-key step command lookup.
// ORIENT_KEYS_EN widens the bitmap to 10 keys with the arrow keys as orientation steps.
package pose_defs;

`ifdef ORIENT_KEYS_EN
  localparam int unsigned NKEYS = 10;
`else
  localparam int unsigned NKEYS = 6;
`endif
  localparam int unsigned IDX_W = $clog2(NKEYS);

  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_D     = 8'h23;
  localparam logic [7:0] SC_SHIFT = 8'h12;
  localparam logic [7:0] SC_SPACE = 8'h29;
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;

  localparam int KEY_W     = 0;
  localparam int KEY_A     = 1;
  localparam int KEY_S     = 2;
  localparam int KEY_D     = 3;
  localparam int KEY_SHIFT = 4;
  localparam int KEY_SPACE = 5;
  localparam int KEY_UP    = 6;
  localparam int KEY_DOWN  = 7;
  localparam int KEY_LEFT  = 8;
  localparam int KEY_RIGHT = 9;

  typedef enum logic [1:0] {AxisX = 2'd0, AxisY = 2'd1, AxisZ = 2'd2} axis_e;

  typedef struct packed {
    logic  kind;
    axis_e axis;
    logic  dir;
  } step_cmd_t;

  function automatic logic [NKEYS-1:0] base_key_mask(input logic [7:0] code);
    logic [NKEYS-1:0] m;
    m = '0;
    case (code)
      SC_W:     m[KEY_W]     = 1'b1;
      SC_A:     m[KEY_A]     = 1'b1;
      SC_S:     m[KEY_S]     = 1'b1;
      SC_D:     m[KEY_D]     = 1'b1;
      SC_SHIFT: m[KEY_SHIFT] = 1'b1;
      SC_SPACE: m[KEY_SPACE] = 1'b1;
      default:  m = '0;
    endcase
    return m;
  endfunction

`ifdef ORIENT_KEYS_EN
  function automatic logic [NKEYS-1:0] ext_key_mask(input logic [7:0] code);
    logic [NKEYS-1:0] m;
    m = '0;
    case (code)
      SC_UP:    m[KEY_UP]    = 1'b1;
      SC_DOWN:  m[KEY_DOWN]  = 1'b1;
      SC_LEFT:  m[KEY_LEFT]  = 1'b1;
      SC_RIGHT: m[KEY_RIGHT] = 1'b1;
      default:  m = '0;
    endcase
    return m;
  endfunction
`endif

  // Opposing keys on one axis cancel: both bits are dropped.
  function automatic logic [NKEYS-1:0] drop_opposing(input logic [NKEYS-1:0] k);
    logic [NKEYS-1:0] r;
    r = k;
    if (k[KEY_W] && k[KEY_S]) begin
      r[KEY_W] = 1'b0;
      r[KEY_S] = 1'b0;
    end
    if (k[KEY_A] && k[KEY_D]) begin
      r[KEY_A] = 1'b0;
      r[KEY_D] = 1'b0;
    end
    if (k[KEY_SHIFT] && k[KEY_SPACE]) begin
      r[KEY_SHIFT] = 1'b0;
      r[KEY_SPACE] = 1'b0;
    end
`ifdef ORIENT_KEYS_EN
    if (k[KEY_UP] && k[KEY_DOWN]) begin
      r[KEY_UP]   = 1'b0;
      r[KEY_DOWN] = 1'b0;
    end
    if (k[KEY_LEFT] && k[KEY_RIGHT]) begin
      r[KEY_LEFT]  = 1'b0;
      r[KEY_RIGHT] = 1'b0;
    end
`endif
    return r;
  endfunction

  function automatic step_cmd_t key_cmd(input logic [IDX_W-1:0] idx);
    step_cmd_t c;
    c = '{kind: 1'b0, axis: AxisX, dir: 1'b0};
    case (int'(idx))
      KEY_W:     c = '{kind: 1'b0, axis: AxisZ, dir: 1'b0};
      KEY_A:     c = '{kind: 1'b0, axis: AxisX, dir: 1'b0};
      KEY_S:     c = '{kind: 1'b0, axis: AxisZ, dir: 1'b1};
      KEY_D:     c = '{kind: 1'b0, axis: AxisX, dir: 1'b1};
      KEY_SHIFT: c = '{kind: 1'b0, axis: AxisY, dir: 1'b0};
      KEY_SPACE: c = '{kind: 1'b0, axis: AxisY, dir: 1'b1};
`ifdef ORIENT_KEYS_EN
      KEY_UP:    c = '{kind: 1'b1, axis: AxisY, dir: 1'b1};
      KEY_DOWN:  c = '{kind: 1'b1, axis: AxisY, dir: 1'b0};
      KEY_LEFT:  c = '{kind: 1'b1, axis: AxisX, dir: 1'b0};
      KEY_RIGHT: c = '{kind: 1'b1, axis: AxisX, dir: 1'b1};
`endif
      default:   c = '{kind: 1'b0, axis: AxisX, dir: 1'b0};
    endcase
    return c;
  endfunction

  // Lowest set bit at or after start, wrapping; returns start when snap is empty.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NKEYS-1:0] snap,
                                               input logic [IDX_W-1:0] start);
    logic [2*NKEYS-1:0] dbl;
    logic [NKEYS-1:0]   rot;
    int                 off;
    int                 sum;
    dbl = {snap, snap} >> start;
    rot = dbl[NKEYS-1:0];
    off = 0;
    for (int i = int'(NKEYS) - 1; i >= 0; i--) begin
      if (rot[i]) off = i;
    end
    sum = int'(start) + off;
    if (sum >= int'(NKEYS)) sum = sum - int'(NKEYS);
    return IDX_W'(sum);
  endfunction

  function automatic logic [IDX_W-1:0] inc_idx(input logic [IDX_W-1:0] idx);
    return (int'(idx) == int'(NKEYS) - 1) ? '0 : idx + 1'b1;
  endfunction

endpackage

// File: rtl/ps2_key_tracker.sv
// PS/2 make/break parser maintaining the held-key bitmap.
// With ORIENT_KEYS_EN, E0-prefixed arrow keys also set/clear bitmap bits.
module ps2_key_tracker
  import pose_defs::*;
(
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic [7:0]       scan_code,
  input  logic             scan_valid,
  output logic [NKEYS-1:0] held_keys
);

  typedef enum logic [1:0] {PIdle, PExt, PBrk, PExtBrk} parse_state_e;

  parse_state_e     state;
  logic [NKEYS-1:0] base_mask;
  logic [NKEYS-1:0] ext_mask;

  assign base_mask = base_key_mask(scan_code);
`ifdef ORIENT_KEYS_EN
  assign ext_mask = ext_key_mask(scan_code);
`else
  assign ext_mask = '0;
`endif

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state     <= PIdle;
      held_keys <= '0;
    end else if (scan_valid) begin
      unique case (state)
        PIdle: begin
          if (scan_code == SC_EXT) begin
            state <= PExt;
          end else if (scan_code == SC_BRK) begin
            state <= PBrk;
          end else begin
            held_keys <= held_keys | base_mask;
            state     <= PIdle;
          end
        end
        PExt: begin
          if (scan_code == SC_BRK) begin
            state <= PExtBrk;
          end else begin
            held_keys <= held_keys | ext_mask;
            state     <= PIdle;
          end
        end
        PBrk: begin
          held_keys <= held_keys & ~base_mask;
          state     <= PIdle;
        end
        PExtBrk: begin
          held_keys <= held_keys & ~ext_mask;
          state     <= PIdle;
        end
        default: state <= PIdle;
      endcase
    end
  end

endmodule

// File: rtl/pose_step_scheduler.sv
// Rate-limited step scheduler: snapshots held keys every tick and issues them round-robin.
// ORIENT_KEYS_EN enables the orientation (arrow key) steps.
module pose_step_scheduler
  import pose_defs::*;
#(
  parameter int unsigned TICK_CYCLES = 10_000_000
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic [7:0]       scan_code,
  input  logic             scan_valid,
  output logic             step_valid,
  input  logic             step_ready,
  output logic             step_kind,
  output logic [1:0]       step_axis,
  output logic             step_dir,
  output logic [NKEYS-1:0] held_keys,
  output logic             overrun
);

  localparam int unsigned CNT_W = $clog2(TICK_CYCLES);

  typedef enum logic {SIdle, SIssue} issue_state_e;

  issue_state_e     state;
  logic [CNT_W-1:0] tick_cnt;
  logic             tick;
  logic [NKEYS-1:0] snapshot;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] cur_idx;
  logic [NKEYS-1:0] cur_mask;
  logic [NKEYS-1:0] snap_rem;
  logic [NKEYS-1:0] pick_src;
  logic [IDX_W-1:0] next_start;
  logic [IDX_W-1:0] pick_start;
  logic [IDX_W-1:0] pick;
  step_cmd_t        pick_cmd;

  ps2_key_tracker u_tracker (
    .CLOCK_50  (CLOCK_50),
    .reset     (reset),
    .scan_code (scan_code),
    .scan_valid(scan_valid),
    .held_keys (held_keys)
  );

  assign tick = (held_keys != '0) && (tick_cnt == CNT_W'(TICK_CYCLES - 1));

  // While issuing, look ahead past the step currently on the bus so the next one
  // can follow in the cycle after the handshake.
  assign cur_mask   = {{(NKEYS - 1){1'b0}}, 1'b1} << cur_idx;
  assign snap_rem   = snapshot & ~cur_mask;
  assign next_start = inc_idx(cur_idx);
  assign pick_src   = (state == SIssue) ? snap_rem : snapshot;
  assign pick_start = (state == SIssue) ? next_start : rr_ptr;
  assign pick       = rr_pick(pick_src, pick_start);
  assign pick_cmd   = key_cmd(pick);

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state      <= SIdle;
      tick_cnt   <= '0;
      snapshot   <= '0;
      rr_ptr     <= '0;
      cur_idx    <= '0;
      step_valid <= 1'b0;
      step_kind  <= 1'b0;
      step_axis  <= 2'd0;
      step_dir   <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (held_keys == '0 || tick) begin
        tick_cnt <= '0;
      end else begin
        tick_cnt <= tick_cnt + 1'b1;
      end

      // Snapshot is non-zero throughout SIssue, so the tick load and the
      // handshake update below never coincide.
      if (tick) begin
        if (snapshot == '0) begin
          snapshot <= drop_opposing(held_keys);
        end else begin
          overrun <= 1'b1;
        end
      end

      unique case (state)
        SIdle: begin
          if (snapshot != '0) begin
            state                              <= SIssue;
            step_valid                         <= 1'b1;
            cur_idx                            <= pick;
            {step_kind, step_axis, step_dir}   <= pick_cmd;
          end
        end
        SIssue: begin
          if (step_ready) begin
            snapshot <= snap_rem;
            rr_ptr   <= next_start;
            if (snap_rem == '0) begin
              state      <= SIdle;
              step_valid <= 1'b0;
            end else begin
              cur_idx                          <= pick;
              {step_kind, step_axis, step_dir} <= pick_cmd;
            end
          end
        end
        default: state <= SIdle;
      endcase
    end
  end

endmodule
